unit_arbiter: RTL and testbench

//  Shares the execution units (ALU, MEM) between NUM_THREADS thread cores.

---
 rtl/unit_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_unit_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_arbiter.sv
// Shares the ALU and MEM units among NUM_THREADS threads, each unit with its own round-robin arbiter.
// Latency is zero: a grant, its operands and the unit result all pass through in the same cycle.
// Backpressure: th_ready stays low until the unit finishes; a granted thread holds the unit until its ready.
package unit_arbiter_pkg;
    typedef logic [1:0] unit_sel_t;
    localparam unit_sel_t SEL_NONE = 2'd0;
    localparam unit_sel_t SEL_ALU  = 2'd1;
    localparam unit_sel_t SEL_MEM  = 2'd2;
    typedef logic [7:0]  ctrl_t;
    typedef logic [31:0] word_t;
endpackage

// Round-robin arbiter for one execution unit. Its grant stays with the owner until the unit is ready.
module unit_arb_chan
    import unit_arbiter_pkg::*;
#(
    parameter int        NUM_THREADS = 2,
    parameter int        ID_W        = 1,
    parameter unit_sel_t UNIT        = SEL_ALU
) (
    input  logic                              clk,
    input  logic                              rst,
    input  unit_sel_t [NUM_THREADS-1:0]       th_sel,
    input  ctrl_t     [NUM_THREADS-1:0]       th_ctrl,
    input  word_t     [NUM_THREADS-1:0][1:0]  th_in,
    input  logic                              unit_ready,
    output logic                              unit_req,
    output ctrl_t                             unit_ctrl,
    output word_t     [1:0]                   unit_in,
    output logic      [NUM_THREADS-1:0]       ack,
    output logic      [ID_W-1:0]              owner_dbg
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        owner, owner_nxt;
    logic [ID_W-1:0]        ptr, ptr_nxt;
    logic [ID_W-1:0]        cand;
    logic                   found;
    logic [NUM_THREADS-1:0] hit;
    int                     idx;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        return (int'(x) == NUM_THREADS - 1) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            hit[i] = (th_sel[i] == UNIT);
        end
    end

    // First requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
            if (!found && hit[idx]) begin
                found = 1'b1;
                cand  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unit_req  = 1'b0;
        unit_ctrl = '0;
        unit_in   = '0;
        ack       = '0;
        owner_dbg = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    unit_req  = 1'b1;
                    unit_ctrl = th_ctrl[cand];
                    unit_in   = th_in[cand];
                    owner_dbg = cand;
                    owner_nxt = cand;
                    if (unit_ready) begin
                        ack[cand] = 1'b1;
                        ptr_nxt   = wrap_inc(cand);
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // An owner that stops selecting this unit has been reset; release without advancing ptr.
                if (!hit[owner]) begin
                    state_nxt = IDLE;
                end else begin
                    unit_req  = 1'b1;
                    unit_ctrl = th_ctrl[owner];
                    unit_in   = th_in[owner];
                    if (unit_ready) begin
                        ack[owner] = 1'b1;
                        ptr_nxt    = wrap_inc(owner);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end
endmodule

module unit_arbiter
    import unit_arbiter_pkg::*;
#(
    parameter int   NUM_THREADS = 2,
    localparam int  ID_W        = $clog2(NUM_THREADS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  unit_sel_t [NUM_THREADS-1:0]       th_sel,
    input  ctrl_t     [NUM_THREADS-1:0]       th_ctrl,
    input  word_t     [NUM_THREADS-1:0][1:0]  th_in,
    output word_t     [NUM_THREADS-1:0]       th_out,
    output logic      [NUM_THREADS-1:0]       th_ready,
    output logic                              alu_req,
    output ctrl_t                             alu_ctrl,
    output word_t     [1:0]                   alu_in,
    input  word_t                             alu_out,
    input  logic                              alu_ready,
    output logic                              mem_req,
    output ctrl_t                             mem_ctrl,
    output word_t     [1:0]                   mem_in,
    input  word_t                             mem_out,
    input  logic                              mem_ready,
    output logic      [ID_W-1:0]              alu_owner,
    output logic      [ID_W-1:0]              mem_owner
);
    logic [NUM_THREADS-1:0] alu_ack;
    logic [NUM_THREADS-1:0] mem_ack;

    unit_arb_chan #(.NUM_THREADS(NUM_THREADS), .ID_W(ID_W), .UNIT(SEL_ALU)) u_alu_arb (
        .clk(clk), .rst(rst), .th_sel(th_sel), .th_ctrl(th_ctrl), .th_in(th_in),
        .unit_ready(alu_ready), .unit_req(alu_req), .unit_ctrl(alu_ctrl), .unit_in(alu_in),
        .ack(alu_ack), .owner_dbg(alu_owner)
    );

    unit_arb_chan #(.NUM_THREADS(NUM_THREADS), .ID_W(ID_W), .UNIT(SEL_MEM)) u_mem_arb (
        .clk(clk), .rst(rst), .th_sel(th_sel), .th_ctrl(th_ctrl), .th_in(th_in),
        .unit_ready(mem_ready), .unit_req(mem_req), .unit_ctrl(mem_ctrl), .unit_in(mem_in),
        .ack(mem_ack), .owner_dbg(mem_owner)
    );

    // Unknown select encodings fall through as NONE: ready with a zero result.
    always_comb begin
        th_ready = '1;
        th_out   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (th_sel[i] == SEL_ALU) begin
                th_ready[i] = alu_ack[i];
                if (alu_ack[i]) th_out[i] = alu_out;
            end else if (th_sel[i] == SEL_MEM) begin
                th_ready[i] = mem_ack[i];
                if (mem_ack[i]) th_out[i] = mem_out;
            end
        end
    end
endmodule

// File: tb/tb_unit_arbiter.sv
// Scoreboard bench for unit_arbiter with two threads; the ALU adds and the MEM XORs its operands.
module tb_unit_arbiter;
    import unit_arbiter_pkg::*;

    typedef struct packed {
        logic [1:0]  rdy;
        word_t [1:0] out;
        logic        areq;
        ctrl_t       actl;
        word_t [1:0] ain;
        logic        mreq;
        ctrl_t       mctl;
        word_t [1:0] min;
        logic        aown;
        logic        mown;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    unit_sel_t [1:0]      th_sel;
    ctrl_t     [1:0]      th_ctrl;
    word_t     [1:0][1:0] th_in;
    word_t     [1:0]      th_out;
    logic      [1:0]      th_ready;
    logic                 alu_req, mem_req, alu_ready, mem_ready;
    ctrl_t                alu_ctrl, mem_ctrl;
    word_t     [1:0]      alu_in, mem_in;
    word_t                alu_out, mem_out;
    logic      [0:0]      alu_owner, mem_owner;

    exp_t obs;
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign alu_out = alu_in[0] + alu_in[1];
    assign mem_out = mem_in[0] ^ mem_in[1];
    assign obs = {th_ready, th_out, alu_req, alu_ctrl, alu_in, mem_req, mem_ctrl, mem_in, alu_owner, mem_owner};

    unit_arbiter #(.NUM_THREADS(2)) dut (
        .clk(clk), .rst(rst),
        .th_sel(th_sel), .th_ctrl(th_ctrl), .th_in(th_in),
        .th_out(th_out), .th_ready(th_ready),
        .alu_req(alu_req), .alu_ctrl(alu_ctrl), .alu_in(alu_in),
        .alu_out(alu_out), .alu_ready(alu_ready),
        .mem_req(mem_req), .mem_ctrl(mem_ctrl), .mem_in(mem_in),
        .mem_out(mem_out), .mem_ready(mem_ready),
        .alu_owner(alu_owner), .mem_owner(mem_owner)
    );

    // Result code per thread: 0 none, 1 ALU sum, 2 MEM xor.
    function automatic word_t res(input int i, input int code);
        if (code == 1) return th_in[i][0] + th_in[i][1];
        if (code == 2) return th_in[i][0] ^ th_in[i][1];
        return '0;
    endfunction

    // a/m: thread whose operands should appear on ALU/MEM, -1 for no request.
    function automatic exp_t mk(input logic [1:0] rdy, input int o0, input int o1,
                                input int a, input int m, input int ao, input int mo);
        exp_t e;
        e        = '0;
        e.rdy    = rdy;
        e.out[0] = res(0, o0);
        e.out[1] = res(1, o1);
        if (a >= 0) begin
            e.areq = 1'b1;
            e.actl = th_ctrl[a];
            e.ain  = th_in[a];
        end
        if (m >= 0) begin
            e.mreq = 1'b1;
            e.mctl = th_ctrl[m];
            e.min  = th_in[m];
        end
        e.aown = (ao != 0);
        e.mown = (mo != 0);
        return e;
    endfunction

    task automatic new_operands();
        for (int i = 0; i < 2; i++) begin
            th_ctrl[i] = ctrl_t'($urandom);
            for (int k = 0; k < 2; k++) th_in[i][k] = $urandom;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        th_sel = {SEL_NONE, SEL_NONE};
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        new_operands();
        sb.push_back(mk(2'b11, 0, 0, -1, -1, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL reset_idle got %h exp %h", obs, e); else n_pass++;
        th_sel[0] = SEL_ALU;
        sb.push_back(mk(2'b10, 0, 0, 0, -1, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL reset_grant got %h exp %h", obs, e); else n_pass++;
        @(posedge clk);
        #1;
        th_sel = {SEL_NONE, SEL_NONE};
        rst = 1'b1;
    endtask

    // Row: sel0, sel1, alu_ready, mem_ready, rdy, o0, o1, alu thread, mem thread, alu_owner, mem_owner
    task automatic test_alu_pair();
        int   tbl[2][11] = '{'{1,1,1,0, 1, 1,0,  0,-1, 0,0},
                             '{1,1,1,0, 2, 0,1,  1,-1, 1,0}};
        exp_t e;
        new_operands();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            th_sel    = {unit_sel_t'(tbl[c][1]), unit_sel_t'(tbl[c][0])};
            alu_ready = (tbl[c][2] != 0);
            mem_ready = (tbl[c][3] != 0);
            sb.push_back(mk(2'(tbl[c][4]), tbl[c][5], tbl[c][6], tbl[c][7], tbl[c][8], tbl[c][9], tbl[c][10]));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL alu_pair c%0d got %h exp %h", c, obs, e); else n_pass++;
        end
    endtask

    task automatic test_split();
        exp_t e;
        new_operands();
        @(posedge clk);
        #1;
        th_sel    = {SEL_ALU, SEL_MEM};
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        sb.push_back(mk(2'b11, 2, 1, 1, 0, 1, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL split got %h exp %h", obs, e); else n_pass++;
    endtask

    task automatic test_mem_hold();
        int   tbl[4][11] = '{'{2,0,0,0, 2, 0,0, -1,0, 1,0},
                             '{2,2,0,0, 0, 0,0, -1,0, 1,0},
                             '{2,2,0,1, 1, 2,0, -1,0, 1,0},
                             '{0,2,0,1, 3, 0,2, -1,1, 1,1}};
        exp_t e;
        new_operands();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            th_sel    = {unit_sel_t'(tbl[c][1]), unit_sel_t'(tbl[c][0])};
            alu_ready = (tbl[c][2] != 0);
            mem_ready = (tbl[c][3] != 0);
            sb.push_back(mk(2'(tbl[c][4]), tbl[c][5], tbl[c][6], tbl[c][7], tbl[c][8], tbl[c][9], tbl[c][10]));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL mem_hold c%0d got %h exp %h", c, obs, e); else n_pass++;
        end
    endtask

    task automatic test_none();
        int   tbl[2][11] = '{'{0,0,1,1, 3, 0,0, -1,-1, 1,1},
                             '{3,3,1,1, 3, 0,0, -1,-1, 1,1}};
        exp_t e;
        new_operands();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            th_sel    = {unit_sel_t'(tbl[c][1]), unit_sel_t'(tbl[c][0])};
            alu_ready = (tbl[c][2] != 0);
            mem_ready = (tbl[c][3] != 0);
            sb.push_back(mk(2'(tbl[c][4]), tbl[c][5], tbl[c][6], tbl[c][7], tbl[c][8], tbl[c][9], tbl[c][10]));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL none c%0d got %h exp %h", c, obs, e); else n_pass++;
        end
    endtask

    task automatic test_owner_drop();
        int   tbl[3][11] = '{'{1,0,0,0, 2, 0,0,  0,-1, 0,1},
                             '{0,1,0,0, 1, 0,0, -1,-1, 0,1},
                             '{1,1,1,0, 1, 1,0,  0,-1, 0,1}};
        exp_t e;
        new_operands();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            th_sel    = {unit_sel_t'(tbl[c][1]), unit_sel_t'(tbl[c][0])};
            alu_ready = (tbl[c][2] != 0);
            mem_ready = (tbl[c][3] != 0);
            sb.push_back(mk(2'(tbl[c][4]), tbl[c][5], tbl[c][6], tbl[c][7], tbl[c][8], tbl[c][9], tbl[c][10]));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL owner_drop c%0d got %h exp %h", c, obs, e); else n_pass++;
        end
    endtask

    task automatic test_reset_busy();
        exp_t e;
        new_operands();
        @(posedge clk);
        #1;
        th_sel    = {SEL_MEM, SEL_NONE};
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        sb.push_back(mk(2'b01, 0, 0, -1, 1, 0, 1));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL rst_busy grant got %h exp %h", obs, e); else n_pass++;
        @(posedge clk);
        #1;
        th_sel = {SEL_MEM, SEL_MEM};
        sb.push_back(mk(2'b00, 0, 0, -1, 1, 0, 1));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL rst_busy locked got %h exp %h", obs, e); else n_pass++;
        #1;
        rst = 1'b0;
        sb.push_back(mk(2'b00, 0, 0, -1, 0, 0, 0));
        #1;
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL rst_busy in_reset got %h exp %h", obs, e); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        sb.push_back(mk(2'b01, 2, 0, -1, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL rst_busy first got %h exp %h", obs, e); else n_pass++;
        @(posedge clk);
        #1;
        sb.push_back(mk(2'b10, 0, 2, -1, 1, 0, 1));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL rst_busy second got %h exp %h", obs, e); else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   exp_ptr = 0;
        new_operands();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            th_sel    = {SEL_ALU, SEL_ALU};
            alu_ready = 1'b1;
            mem_ready = 1'b0;
            sb.push_back(mk((exp_ptr == 0) ? 2'b01 : 2'b10, (exp_ptr == 0) ? 1 : 0,
                            (exp_ptr == 1) ? 1 : 0, exp_ptr, -1, exp_ptr, 1));
            exp_ptr = (exp_ptr + 1) % 2;
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL round_robin c%0d got %h exp %h", c, obs, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_split();
        test_mem_hold();
        test_none();
        test_owner_drop();
        test_reset_busy();
        test_round_robin();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_chk);
        $fatal(1);
    end
endmodule
